// File: rtl/bus_fetch_sequencer.sv
// Instruction-fetch bus sequencer: T0 PC->MAR, T1 ZLow->PC + memory read, T2 MDR->IR, then execute handoff.
// Define BUS_SEQ_TIMEOUT_EN to enable the memory-read timeout into a sticky FAULT state.
module bus_fetch_sequencer #(
   parameter logic [4:0] SEL_PC      = 5'd20,
   parameter logic [4:0] SEL_ZLOW    = 5'd19,
   parameter logic [4:0] SEL_MDR     = 5'd21,
   parameter logic [4:0] SEL_IDLE    = 5'd31,
   parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        run,
   input  logic        stop,
   input  logic        mem_ready,
   input  logic        exec_done,
   output logic [4:0]  bus_sel,
   output logic        mar_in,
   output logic        inc_pc,
   output logic        z_in,
   output logic        pc_in,
   output logic        mem_read,
   output logic        mdr_in,
   output logic        ir_in,
   output logic        exec_start,
   output logic        busy,
   output logic        fault,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_EXEC, S_FAULT
   } state_t;

   typedef struct packed {
      logic mar_in;
      logic inc_pc;
      logic z_in;
      logic pc_in;
      logic mem_read;
      logic ir_in;
      logic exec_start;
      logic busy;
      logic fault;
   } ctl_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] instr_cnt_q, instr_cnt_d;
   logic [4:0]  bus_sel_q, bus_sel_d;
   ctl_t        ctl_q, ctl_d;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      instr_cnt_d = instr_cnt_q;
      case (state_q)
         S_IDLE:  if (run && !stop) state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1: begin
            state_d    = S_T1W;
            wait_cnt_d = '0;
         end
         S_T1W: begin
            if (mem_ready) begin
               state_d = S_T2;
            end else begin
               wait_cnt_d = (wait_cnt_q == MEM_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 4'd1;
`ifdef BUS_SEQ_TIMEOUT_EN
               if (wait_cnt_d == MEM_TIMEOUT) state_d = S_FAULT;
`endif
            end
         end
         S_T2: begin
            state_d     = S_EXEC;
            instr_cnt_d = instr_cnt_q + 16'd1;
         end
         S_EXEC:  if (exec_done) state_d = (run && !stop) ? S_T0 : S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      bus_sel_d = SEL_IDLE;
      ctl_d     = '0;
      case (state_d)
         S_T0: begin
            bus_sel_d    = SEL_PC;
            ctl_d.mar_in = 1'b1;
            ctl_d.inc_pc = 1'b1;
            ctl_d.z_in   = 1'b1;
         end
         S_T1: begin
            bus_sel_d      = SEL_ZLOW;
            ctl_d.pc_in    = 1'b1;
            ctl_d.mem_read = 1'b1;
         end
         S_T1W:   ctl_d.mem_read = 1'b1;
         S_T2: begin
            bus_sel_d   = SEL_MDR;
            ctl_d.ir_in = 1'b1;
         end
         S_EXEC:  ctl_d.exec_start = (state_q != S_EXEC);
`ifdef BUS_SEQ_TIMEOUT_EN
         S_FAULT: ctl_d.fault = 1'b1;
`endif
         default: ctl_d = '0;
      endcase
      ctl_d.busy = (state_d != S_IDLE) && (state_d != S_FAULT);
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         instr_cnt_q <= '0;
         bus_sel_q   <= SEL_IDLE;
         ctl_q       <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         instr_cnt_q <= instr_cnt_d;
         bus_sel_q   <= bus_sel_d;
         ctl_q       <= ctl_d;
      end
   end

   assign bus_sel     = bus_sel_q;
   assign mar_in      = ctl_q.mar_in;
   assign inc_pc      = ctl_q.inc_pc;
   assign z_in        = ctl_q.z_in;
   assign pc_in       = ctl_q.pc_in;
   assign mem_read    = ctl_q.mem_read;
   assign ir_in       = ctl_q.ir_in;
   assign exec_start  = ctl_q.exec_start;
   assign busy        = ctl_q.busy;
   assign fault       = ctl_q.fault;
   assign instr_count = instr_cnt_q;

   // MDR must capture in the very cycle memory data is valid, so it follows the live handshake.
   assign mdr_in = (state_q == S_T1W) && mem_ready;

endmodule

// File: tb/tb_bus_fetch_sequencer.sv
// Self-checking bench for bus_fetch_sequencer: directed fetch scenarios plus random traffic
// against a per-cycle phase model of the fetch protocol.
module tb_bus_fetch_sequencer;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0, run = 1'b0, stop = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
   logic [4:0]  bus_sel;
   logic        mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in, exec_start, busy, fault;
   logic [15:0] instr_count;

   always #5 clock = ~clock;

   bus_fetch_sequencer dut (
      .clock(clock), .clear_n(clear_n), .run(run), .stop(stop),
      .mem_ready(mem_ready), .exec_done(exec_done),
      .bus_sel(bus_sel), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .pc_in(pc_in),
      .mem_read(mem_read), .mdr_in(mdr_in), .ir_in(ir_in), .exec_start(exec_start),
      .busy(busy), .fault(fault), .instr_count(instr_count)
   );

   localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T1W = 3, P_T2 = 4, P_EXEC = 5, P_FAULT = 6;

   int m_ph, m_wait, m_age, m_cnt;
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {bus_sel, mar, inc, z, pc, mem_read, mdr, ir, exec_start, busy, fault}
   function automatic logic [14:0] exp_vec(input bit mr);
      logic [4:0] b;
      logic [9:0] s;
      b = 5'd31;
      s = '0;
      case (m_ph)
         P_T0:    begin b = 5'd20; s[9] = 1; s[8] = 1; s[7] = 1; s[1] = 1; end
         P_T1:    begin b = 5'd19; s[6] = 1; s[5] = 1; s[1] = 1; end
         P_T1W:   begin s[5] = 1; s[4] = mr; s[1] = 1; end
         P_T2:    begin b = 5'd21; s[3] = 1; s[1] = 1; end
         P_EXEC:  begin s[2] = (m_age == 0); s[1] = 1; end
         P_FAULT: s[0] = 1;
         default: s = '0;
      endcase
      return {b, s};
   endfunction

   task automatic model_step(input bit r, input bit s, input bit mr, input bit ed, input bit cl);
      if (!cl) begin
         m_ph = P_IDLE; m_cnt = 0; m_wait = 0; m_age = 0;
         return;
      end
      case (m_ph)
         P_IDLE: if (r && !s) m_ph = P_T0;
         P_T0:   m_ph = P_T1;
         P_T1:   begin m_ph = P_T1W; m_wait = 0; end
         P_T1W: begin
            if (mr) m_ph = P_T2;
            else begin
               m_wait++;
`ifdef BUS_SEQ_TIMEOUT_EN
               if (m_wait == 15) m_ph = P_FAULT;
`endif
            end
         end
         P_T2:   begin m_ph = P_EXEC; m_age = 0; m_cnt = (m_cnt + 1) % 65536; end
         P_EXEC: begin m_age++; if (ed) m_ph = (r && !s) ? P_T0 : P_IDLE; end
         default: ;
      endcase
   endtask

   // One clock: drive inputs at the falling edge, check the current cycle's outputs, advance the model.
   task automatic cyc(input bit r, input bit s, input bit mr, input bit ed, input bit cl);
      @(negedge clock);
      run = r; stop = s; mem_ready = mr; exec_done = ed; clear_n = cl;
      #1;
      chk("outs", {17'd0, bus_sel, mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in,
                   exec_start, busy, fault}, {17'd0, exp_vec(mr)});
      chk("icnt", {16'd0, instr_count}, 32'(m_cnt));
      model_step(r, s, mr, ed, cl);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] seq, seq_exp;
      int n_mrd, n_pc, n_mdr;
      clear_n = 1'b0;
      repeat (2) @(posedge clock);
      m_ph = P_IDLE; m_cnt = 0; m_wait = 0; m_age = 0;

      // reset state
      cyc(0, 0, 0, 0, 0);
      chk("rst_bus", {27'd0, bus_sel}, 32'd31);
      chk("rst_icnt", {16'd0, instr_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // back-to-back fetch, memory always ready, exec_done two cycles after exec_start
      cyc(1, 0, 1, 0, 1);
      seq = '0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 1, 0, 1);
         seq = {seq[19:0], bus_sel};
      end
      seq_exp = {5'd20, 5'd19, 5'd31, 5'd21, 5'd31};
      chk("t1_seq", {7'd0, seq}, {7'd0, seq_exp});
      chk("t1_start", {31'd0, exec_start}, 32'd1);
      chk("t1_icnt", {16'd0, instr_count}, 32'd1);
      cyc(1, 0, 1, 0, 1);
      cyc(1, 0, 1, 1, 1);
      cyc(1, 0, 0, 0, 1);
      chk("t1_t0", {27'd0, bus_sel}, 32'd20);

      // five wait cycles in T1W
      n_mrd = 0; n_pc = 0; n_mdr = 0;
      cyc(1, 0, 0, 0, 1);
      n_pc += int'(pc_in);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, (i == 5), 0, 1);
         n_mrd += int'(mem_read); n_pc += int'(pc_in); n_mdr += int'(mdr_in);
         if (i == 5) chk("t2_mdr_rdy", {31'd0, mdr_in}, 32'd1);
      end
      cyc(1, 0, 0, 0, 1);
      n_pc += int'(pc_in); n_mdr += int'(mdr_in);
      chk("t2_mrd", 32'(n_mrd), 32'd6);
      chk("t2_pc", 32'(n_pc), 32'd1);
      chk("t2_mdr", 32'(n_mdr), 32'd1);
      chk("t2_ir", {31'd0, ir_in}, 32'd1);

      // exec_done in the exec_start cycle, then stop raised in T1
      cyc(1, 0, 0, 1, 1);
      chk("t3_es_done", {31'd0, exec_start}, 32'd1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 1, 0, 1);
      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 1);
      chk("t3_es", {31'd0, exec_start}, 32'd1);
      cyc(1, 1, 0, 1, 1);
      cyc(1, 1, 0, 0, 1);
      chk("t3_busy", {31'd0, busy}, 32'd0);
      chk("t3_bus", {27'd0, bus_sel}, 32'd31);
      chk("t3_icnt", {16'd0, instr_count}, 32'd3);

      // clear during T1W
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      chk("t4_mrd", {31'd0, mem_read}, 32'd1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t4_strb", {22'd0, mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in,
                      exec_start, busy, fault}, 32'd0);
      chk("t4_icnt", {16'd0, instr_count}, 32'd0);

`ifdef BUS_SEQ_TIMEOUT_EN
      // memory never answers
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      n_mrd = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1, 0, 0, 0, 1);
         n_mrd += int'(mem_read);
      end
      chk("t5_waits", 32'(n_mrd), 32'd15);
      cyc(1, 0, 0, 0, 1);
      chk("t5_fault", {29'd0, fault, busy, mem_read}, 32'd4);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 1);
      chk("t5_sticky", {31'd0, fault}, 32'd1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t5_clr", {31'd0, fault}, 32'd0);
`endif

      // counter wrap from 0xFFFF
      force dut.instr_cnt_q = 16'hFFFF;
      @(posedge clock);
      #1;
      release dut.instr_cnt_q;
      m_cnt = 65535;
      cyc(0, 0, 0, 0, 1);
      chk("t6_pre", {16'd0, instr_count}, 32'h0000FFFF);
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 1);
      chk("t6_wrap", {16'd0, instr_count}, 32'd0);
      cyc(0, 0, 0, 1, 1);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
